// File: rtl/mul_addtree_pipe.sv
// rtl/mul_addtree_pipe.sv - pipelined WIDTH x WIDTH multiplier with registered partial products and adder tree
// Optional two's complement operation is selected by defining MUL_ADDTREE_SIGNED_EN.
module mul_addtree_pipe #(
   parameter int WIDTH = 4,
   localparam int LEVELS = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   mul_a,
   input  logic [WIDTH-1:0]   mul_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] mul_out,
   output logic               busy
);

   localparam int PW    = 2 * WIDTH;
   localparam int NODES = 2 * WIDTH - 1;

   logic [PW-1:0]   a_ext;
   logic [PW-1:0]   pp   [WIDTH];
   logic [PW-1:0]   node [NODES];
   logic [LEVELS:0] vld;
   logic            adv;

   // Tree levels are packed back to back: level l starts where the wider levels end.
   function automatic int base(input int l);
      return 2 * WIDTH - 2 * (WIDTH >> l);
   endfunction

`ifdef MUL_ADDTREE_SIGNED_EN
   assign a_ext = {{WIDTH{mul_a[WIDTH-1]}}, mul_a};
`else
   assign a_ext = {{WIDTH{1'b0}}, mul_a};
`endif

   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         pp[i] = mul_b[i] ? (a_ext << i) : '0;
      end
`ifdef MUL_ADDTREE_SIGNED_EN
      // The multiplier MSB carries negative weight in two's complement.
      pp[WIDTH-1] = '0 - pp[WIDTH-1];
`endif
   end

   assign adv       = !vld[LEVELS] | out_ready;
   assign in_ready  = adv;
   assign out_valid = vld[LEVELS];
   assign mul_out   = node[NODES-1];
   assign busy      = |vld;

   // Data registers only load behind a valid bit, so mul_out keeps the last product across bubbles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
         for (int n = 0; n < NODES; n++) begin
            node[n] <= '0;
         end
      end else if (flush) begin
         vld <= '0;
      end else if (adv) begin
         vld <= {vld[LEVELS-1:0], in_valid};
         if (in_valid) begin
            for (int i = 0; i < WIDTH; i++) begin
               node[i] <= pp[i];
            end
         end
         for (int l = 1; l <= LEVELS; l++) begin
            if (vld[l-1]) begin
               for (int j = 0; j < (WIDTH >> l); j++) begin
                  node[base(l) + j] <= node[base(l-1) + 2*j] + node[base(l-1) + 2*j + 1];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mul_addtree_pipe.sv
// tb/tb_mul_addtree_pipe.sv - scoreboard bench for mul_addtree_pipe at WIDTH=4 and WIDTH=8
module tb_mul_addtree_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush4 = 1'b0, flush8 = 1'b0;
   logic        in_valid4 = 1'b0, in_valid8 = 1'b0;
   logic        in_ready4, in_ready8;
   logic [3:0]  a4 = '0, b4 = '0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        out_valid4, out_valid8;
   logic        out_ready4 = 1'b1, out_ready8 = 1'b1;
   logic [7:0]  mul_out4;
   logic [15:0] mul_out8;
   logic        busy4, busy8;

   typedef struct {
      int exp;
      int cyc;
      int stl;
   } exp_t;

   exp_t q4[$];
   exp_t q8[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   bit   rr4 = 1'b0, rr8 = 1'b0;

   mul_addtree_pipe #(.WIDTH(4)) u4 (
      .clk(clk), .rst(rst), .flush(flush4), .in_valid(in_valid4), .in_ready(in_ready4),
      .mul_a(a4), .mul_b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
      .mul_out(mul_out4), .busy(busy4)
   );

   mul_addtree_pipe #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .flush(flush8), .in_valid(in_valid8), .in_ready(in_ready8),
      .mul_a(a8), .mul_b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
      .mul_out(mul_out8), .busy(busy8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int ref_mul(input int a, input int b, input int w);
      int sa = a;
      int sb = b;
`ifdef MUL_ADDTREE_SIGNED_EN
      if (sa >= (1 << (w - 1))) sa -= (1 << w);
      if (sb >= (1 << (w - 1))) sb -= (1 << w);
`endif
      return (sa * sb) & ((1 << (2 * w)) - 1);
   endfunction

   task automatic check(input bit ok, input string name, input int act, input int req);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   initial begin
      exp_t e;
      bit   hold = 1'b0;
      int   held = 0;
      int   stall = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            q4.delete();
            hold = 1'b0;
         end else begin
            check(in_ready4 == (!out_valid4 || out_ready4), "in_ready4", int'(in_ready4), int'(!out_valid4 || out_ready4));
            if (hold) check(out_valid4 && mul_out4 == held, "hold4", int'(mul_out4), held);
            if (out_valid4) begin
               if (q4.size() == 0) check(1'b0, "unexpected4", int'(mul_out4), -1);
               else if (out_ready4) begin
                  e = q4.pop_front();
                  check(mul_out4 == e.exp, "data4", int'(mul_out4), e.exp);
                  if (e.stl == stall) check(cyc - e.cyc == 3, "latency4", cyc - e.cyc, 3);
               end else stall++;
            end
            hold = out_valid4 && !out_ready4 && !flush4;
            held = int'(mul_out4);
            if (flush4) q4.delete();
            else if (in_valid4 && in_ready4) q4.push_back('{ref_mul(int'(a4), int'(b4), 4), cyc, stall});
         end
      end
   end

   initial begin
      exp_t e;
      bit   hold = 1'b0;
      int   held = 0;
      int   stall = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            q8.delete();
            hold = 1'b0;
         end else begin
            check(in_ready8 == (!out_valid8 || out_ready8), "in_ready8", int'(in_ready8), int'(!out_valid8 || out_ready8));
            if (hold) check(out_valid8 && mul_out8 == held, "hold8", int'(mul_out8), held);
            if (out_valid8) begin
               if (q8.size() == 0) check(1'b0, "unexpected8", int'(mul_out8), -1);
               else if (out_ready8) begin
                  e = q8.pop_front();
                  check(mul_out8 == e.exp, "data8", int'(mul_out8), e.exp);
                  if (e.stl == stall) check(cyc - e.cyc == 4, "latency8", cyc - e.cyc, 4);
               end else stall++;
            end
            hold = out_valid8 && !out_ready8 && !flush8;
            held = int'(mul_out8);
            if (flush8) q8.delete();
            else if (in_valid8 && in_ready8) q8.push_back('{ref_mul(int'(a8), int'(b8), 8), cyc, stall});
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      out_ready4 = rr4 ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready8 = rr8 ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic send4(input int a, input int b);
      bit acc = 1'b0;
      int n = 0;
      a4 = 4'(a);
      b4 = 4'(b);
      in_valid4 = 1'b1;
      do begin
         @(negedge clk);
         acc = in_ready4;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 1000);
      in_valid4 = 1'b0;
      if (!acc) check(1'b0, "accept4", 0, 1);
   endtask

   task automatic send8(input int a, input int b);
      bit acc = 1'b0;
      int n = 0;
      a8 = 8'(a);
      b8 = 8'(b);
      in_valid8 = 1'b1;
      do begin
         @(negedge clk);
         acc = in_ready8;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 1000);
      in_valid8 = 1'b0;
      if (!acc) check(1'b0, "accept8", 0, 1);
   endtask

   task automatic drain();
      int n = 0;
      while ((q4.size() != 0 || q8.size() != 0) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(q4.size() == 0, "drain4", q4.size(), 0);
      check(q8.size() == 0, "drain8", q8.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic quiet4(input string name);
      repeat (6) begin
         @(negedge clk);
         check(out_valid4 == 1'b0, name, int'(out_valid4), 0);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1;
      check(out_valid4 == 1'b0, "rst_out_valid4", int'(out_valid4), 0);
      check(mul_out4 == 8'd0, "rst_mul_out4", int'(mul_out4), 0);
      check(busy4 == 1'b0, "rst_busy4", int'(busy4), 0);
      check(in_ready4 == 1'b1, "rst_in_ready4", int'(in_ready4), 1);
      check(out_valid8 == 1'b0 && mul_out8 == 16'd0, "rst_out8", int'(mul_out8), 0);
      check(in_ready8 == 1'b1, "rst_in_ready8", int'(in_ready8), 1);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      send4(9, 7);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check(out_valid4 == (k == 3), "basic_valid", int'(out_valid4), int'(k == 3));
         if (k == 3) check(mul_out4 == ref_mul(9, 7, 4), "basic_data", int'(mul_out4), ref_mul(9, 7, 4));
      end
      @(posedge clk);
      #1;

      for (int i = 0; i < 256; i++) send4(i >> 4, i & 15);
      drain();

      send4(2, 3);
      send4(4, 5);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k == 2) check(out_valid4 && mul_out4 == ref_mul(2, 3, 4), "arrive_first", int'(mul_out4), ref_mul(2, 3, 4));
         if (k == 3) check(out_valid4 && mul_out4 == ref_mul(4, 5, 4), "arrive_second", int'(mul_out4), ref_mul(4, 5, 4));
      end
      @(posedge clk);
      #1;
      drain();

      send4(8, 8); send4(8, 7); send4(15, 1); send4(7, 7); send4(0, 13); send4(11, 0);
      drain();

      rr4 = 1'b1;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         send4($urandom_range(0, 15), $urandom_range(0, 15));
      end
      rr4 = 1'b0;
      drain();

      rr8 = 1'b1;
      send8(255, 255);
      send8(3, 5);
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            @(posedge clk);
            #1;
         end
         send8($urandom_range(0, 255), $urandom_range(0, 255));
      end
      rr8 = 1'b0;
      drain();

      send4(3, 3);
      send4(5, 6);
      a4 = 4'd7;
      b4 = 4'd2;
      in_valid4 = 1'b1;
      flush4 = 1'b1;
      @(posedge clk);
      #1;
      flush4 = 1'b0;
      in_valid4 = 1'b0;
      check(busy4 == 1'b0, "flush_busy", int'(busy4), 0);
      check(out_valid4 == 1'b0, "flush_valid", int'(out_valid4), 0);
      quiet4("flush_quiet");

      send4(1, 2); send4(3, 4); send4(5, 6);
      #2;
      rst = 1'b1;
      #1;
      check(out_valid4 == 1'b0, "arst_valid", int'(out_valid4), 0);
      check(mul_out4 == 8'd0, "arst_data", int'(mul_out4), 0);
      check(busy4 == 1'b0, "arst_busy", int'(busy4), 0);
      check(in_ready4 == 1'b1, "arst_in_ready", int'(in_ready4), 1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      quiet4("arst_quiet");

      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mul_addtree_pipe.md
Name: mul_addtree_pipe

Overview:
- Parametrised, pipelined successor to the 4x4 combinational add-tree multiplier.
- Multiplies two WIDTH-bit operands. Partial products are registered, then summed by a registered binary adder tree.
- Has valid/ready handshakes on input and output, with full back-pressure.
- Sits between operand sources and datapath consumers where a 2*WIDTH-bit product is needed at one result per clock.

Parameters:
- WIDTH, 4, operand width in bits; must be a power of two, 2..16.
- LEVELS, $clog2(WIDTH), number of adder-tree levels; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-high.
- flush  input  1  synchronous clear of all in-flight operations.
- in_valid  input  1  operand pair on mul_a/mul_b is valid.
- in_ready  output  1  block accepts an operand pair this cycle.
- mul_a  input  WIDTH  multiplicand.
- mul_b  input  WIDTH  multiplier.
- out_valid  output  1  mul_out holds a valid product.
- out_ready  input  1  consumer accepts mul_out this cycle.
- mul_out  output  2*WIDTH  product.
- busy  output  1  at least one operation is in flight in any stage.

Behaviour:
- Reset: rst high asynchronously clears every stage valid bit and data register to 0. While reset is held: out_valid=0, mul_out=0, busy=0, in_ready=1.
- Pipeline structure, LEVELS+1 stages:
  - Stage 0: registers WIDTH partial products pp[i] = mul_b[i] ? (mul_a << i) : 0, each zero-extended to 2*WIDTH bits.
  - Stages 1..LEVELS: each halves the operand count by pairwise addition, registering the sums.
  - The last stage drives mul_out.
- Widths: all sums are 2*WIDTH bits and are truncated to 2*WIDTH bits. No overflow is possible in unsigned mode.
- Latency: exactly LEVELS+1 cycles from an accepted input to out_valid, with no stalls. WIDTH=4 gives 3 cycles; WIDTH=8 gives 4 cycles.
- Throughput: one operation per cycle when out_ready is held high.
- Advance enable: adv = !out_valid | out_ready.
  - All stages shift together only when adv=1.
  - in_ready = adv. This is combinational, from out_valid and out_ready only.
  - Input is accepted when in_valid & in_ready.
- Bubbles: a stage whose valid bit is 0 carries a bubble. Bubbles advance like data and are squeezed only by the global shift; no per-stage collapse.
- Stall: when adv=0, every stage holds its data and valid bit, so mul_out and out_valid are stable. The producer's in_valid must remain asserted until accepted, but the block does not check this.
- Output handshake: the product is consumed on a cycle with out_valid & out_ready.
  - If a new result reaches the last stage on that same cycle, out_valid stays 1 with the new data.
  - Otherwise out_valid falls to 0.
  - mul_out holds its last value when out_valid=0.
- busy is the OR of all stage valid bits.
- flush, synchronous:
  - Clears all valid bits on the next edge. Data registers are don't-care.
  - Any input presented in the same cycle is dropped, even though in_ready may be 1.
  - flush has priority over adv.
- Reset mid-operation: all in-flight results are lost and no out_valid pulse occurs afterwards.
- Zero operands: a zero operand gives mul_out=0 with a normal valid pulse; there is no special-casing.

Optional Feature:
- Macro: MUL_ADDTREE_SIGNED_EN.
- Defined: operands and result are two's complement, so mul_out = $signed(mul_a) * $signed(mul_b) in 2*WIDTH bits.
  - Partial products are sign-extended from mul_a.
  - The MSB partial product (i = WIDTH-1) is negated, i.e. subtracted in the tree.
  - Latency and handshake are unchanged.
- Undefined: unsigned only, as described above. There is no runtime mode pin in either build.

Test Plan:
- Basic latency, WIDTH=4, out_ready=1: rst pulse, then mul_a=4'd9, mul_b=4'd7 with in_valid high for 1 cycle. Expect mul_out=8'd63 and out_valid high for exactly one cycle, 3 cycles after acceptance.
- Streaming: feed all 256 unsigned 4-bit operand pairs back-to-back, with out_ready=1. Expect one result per cycle, in order, each equal to a*b; max 15*15=8'd225.
- Back-pressure, WIDTH=8: stream 8'd255*8'd255, then 8'd3*8'd5, while out_ready toggles randomly with ~50% duty. Expect:
  - in_ready == (!out_valid | out_ready) every cycle.
  - mul_out stable while out_valid & !out_ready.
  - Outputs 16'd65025, then 16'd15; no loss or duplication.
- Flush and reset:
  - Issue 3 operations, then assert flush for 1 cycle. Expect no out_valid, and busy=0 on the next cycle.
  - Repeat, asserting rst asynchronously mid-cycle. Expect out_valid=0 and mul_out=0 immediately.
- Signed build (MUL_ADDTREE_SIGNED_EN), WIDTH=4:
  - -8*-8 gives 8'sd64.
  - -8*7 gives -8'sd56 (8'hC8).
  - -1*1 gives 8'hFF.
  - 7*7 gives 8'd49.
- Simultaneous consume-and-arrive, out_ready=1, back-to-back inputs 2*3 and 4*5: out_valid stays high across consecutive cycles, with mul_out 6 then 20.
